bootrom_patch: RTL and testbench
================================

Name: bootrom_patch

Overview:
- Parametrised successor of the 8x16 boot ROM.
- DEPTH words of DATA_W bits; the lower words are fixed and the top PATCH_N words are writable patch slots.
- Reads are registered, with a valid strobe.
- After reset, a built-in scan FSM computes an additive checksum over all words before the CPU fetch path is enabled. The block sits between the core's instruction-fetch port and the boot address decode.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 8, number of words (≥2; need not be a power of two).
- PATCH_N, 1, number of writable words at the top of the map (1..DEPTH).
- ROM_INIT, {16'h0008,16'h4000,16'h6007,16'hB007,16'hF400,16'hF800,16'h4000,16'hF200}, packed DATA_W*DEPTH reset image; word i is at bits [i*DATA_W +: DATA_W].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  access select.
- we  input  1  1 = write, 0 = read (qualified by cs).
- addr  input  AW=$clog2(DEPTH)  word address.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data; holds between reads.
- rvalid  output  1  one-cycle pulse, dout updated this cycle.
- ready  output  1  scan complete; accesses accepted.
- csum  output  DATA_W  checksum from last completed scan.
- rescan  input  1  pulse: start a new scan (ignored unless ready).
- werr  output  1  sticky write-error flag.
- clr_err  input  1  synchronous clear of werr.
- lock  input  1  present only with BOOTROM_LOCK_EN.

Behaviour:
- Reset (rst_n low, async):
  - Every word loads from ROM_INIT.
  - dout=0, rvalid=0, ready=0, csum=0, werr=0, FSM=IDLE.
- Fixed region:
  - Addresses 0..DEPTH-PATCH_N-1 never change except via reset.
- Scan FSM, states IDLE, SCAN, READY:
  - Clock edge 1 after reset release: IDLE→SCAN, idx=0, acc=0.
  - Each following edge: acc += word[idx] (mod 2^DATA_W), idx++.
  - On the edge that adds word[DEPTH-1]: csum=acc+word, ready=1, →READY.
  - ready therefore rises on edge DEPTH+1 after reset release.
  - rescan in READY: ready=0, →SCAN with idx=0, acc=0. csum holds its old value until the new scan completes.
- Access rules:
  - cs sampled while ready=0 is ignored: no rvalid, no write, no werr.
- Read (ready & cs & ~we at edge N):
  - dout=word[addr], rvalid=1 after edge N (latency 1).
  - Out-of-range addr (≥DEPTH) returns 0 with rvalid=1.
  - Back-to-back reads return one word per cycle.
- Write (ready & cs & we):
  - addr in DEPTH-PATCH_N..DEPTH-1: word=din at the edge.
  - Any other addr (fixed or out of range): no change, werr=1.
- Same-address write then read next cycle returns the new data.
- werr:
  - Cleared by clr_err at the edge.
  - A simultaneous error event wins: werr stays 1.
- rescan and cs asserted in the same READY cycle: rescan wins, the access is dropped.
- Reset mid-scan or mid-access aborts immediately and returns to the reset state above.

Optional Feature:
- Macro: BOOTROM_LOCK_EN.
- With the macro:
  - lock port exists.
  - lock=1 sampled at an edge while ready sets a sticky locked bit, cleared only by reset.
  - While locked, patch writes are rejected, the word is unchanged, and werr=1.
  - Reads and rescan are unaffected.
- Without the macro: no lock port and no locked bit; patch writes are always accepted when ready.

Test Plan:
- Release rst_n with default params → ready=0 through edge 8, ready=1 after edge 9, csum=16'h6E16.
- Read addresses 0..7 back-to-back → dout F200,4000,F800,F400,B007,6007,4000,0008, each one cycle after request, rvalid high every cycle.
- Write 16'h1234 to addr 7, read addr 7 → 1234. Pulse rescan → ready low for 8 cycles, then csum=16'h8042.
- Write 16'hFFFF to addr 3 → werr=1, read addr 3 = F400. clr_err → werr=0.
- Issue a read during scan → no rvalid. Pull rst_n low at scan edge 4 → ready=0, csum=0, then the full re-scan yields 16'h6E16.
- With BOOTROM_LOCK_EN: pulse lock, write 16'hAAAA to addr 7 → werr=1, addr 7 unchanged (0008). Reset clears the lock.

Source files
------------

// File: rtl/bootrom_patch.sv
// Boot ROM with writable patch slots at the top of the map and a post-reset checksum scan.
// Optional BOOTROM_LOCK_EN adds a lock input that freezes the patch slots until reset.
module bootrom_patch #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PATCH_N = 1,
  parameter logic [DATA_W*DEPTH-1:0] ROM_INIT = {16'h0008, 16'h4000, 16'h6007, 16'hB007,
                                                 16'hF400, 16'hF800, 16'h4000, 16'hF200},
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              ready,
  output logic [DATA_W-1:0] csum,
  input  logic              rescan,
  output logic              werr,
  input  logic              clr_err
`ifdef BOOTROM_LOCK_EN
  ,
  input  logic              lock
`endif
);

  localparam int unsigned FIX_N = DEPTH - PATCH_N;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_READY} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] r_dout;
  logic              r_rvalid;
  logic              r_ready;
  logic              r_werr;

  logic [DATA_W-1:0] w_mem [DEPTH];
  logic [31:0]       w_addr_ext;
  logic              w_in_range;
  logic              w_in_patch;
  logic              w_acc_en;
  logic              w_rd;
  logic              w_wr;
  logic              w_wr_ok;
  logic              w_wr_err;
  logic              w_locked;
  logic [DATA_W-1:0] w_scan_word;
  logic [DATA_W-1:0] w_rd_data;

  // Fixed words are wired straight from the image; patch slots are reset-loaded registers.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    if (g < FIX_N) begin : g_fix
      assign w_mem[g] = ROM_INIT[g*DATA_W +: DATA_W];
    end else begin : g_patch
      logic [DATA_W-1:0] r_word;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_word <= ROM_INIT[g*DATA_W +: DATA_W];
        end else if (w_wr_ok && (w_addr_ext == 32'(g))) begin
          r_word <= din;
        end
      end
      assign w_mem[g] = r_word;
    end
  end

  assign w_addr_ext  = 32'(addr);
  assign w_in_range  = w_addr_ext < DEPTH;
  assign w_in_patch  = w_in_range && (w_addr_ext >= FIX_N);
  // A rescan request in READY takes priority over any same-cycle access.
  assign w_acc_en    = (r_state == ST_READY) && cs && !rescan;
  assign w_rd        = w_acc_en && !we;
  assign w_wr        = w_acc_en && we;
  assign w_wr_ok     = w_wr && w_in_patch && !w_locked;
  assign w_wr_err    = w_wr && !w_wr_ok;
  assign w_scan_word = w_mem[r_idx];
  assign w_rd_data   = w_in_range ? w_mem[addr] : '0;

`ifdef BOOTROM_LOCK_EN
  logic r_locked;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
    end else if (r_ready && lock) begin
      r_locked <= 1'b1;
    end
  end
  assign w_locked = r_locked;
`else
  assign w_locked = 1'b0;
`endif

  // Scan FSM plus registered read port and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_acc    <= '0;
      r_csum   <= '0;
      r_ready  <= 1'b0;
      r_dout   <= '0;
      r_rvalid <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_dout <= w_rd_data;
      end
      if (w_wr_err) begin
        r_werr <= 1'b1;
      end else if (clr_err) begin
        r_werr <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_SCAN;
          r_idx   <= '0;
          r_acc   <= '0;
        end
        ST_SCAN: begin
          r_acc <= r_acc + w_scan_word;
          r_idx <= r_idx + AW'(1);
          if (32'(r_idx) == DEPTH - 1) begin
            r_csum  <= r_acc + w_scan_word;
            r_ready <= 1'b1;
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (rescan) begin
            r_ready <= 1'b0;
            r_state <= ST_SCAN;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout   = r_dout;
  assign rvalid = r_rvalid;
  assign ready  = r_ready;
  assign csum   = r_csum;
  assign werr   = r_werr;

endmodule

// File: tb/tb_bootrom_patch.sv
// Scoreboard bench for bootrom_patch: reads queue their expected word, a monitor pops on rvalid.
module tb_bootrom_patch;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic          rescan = 1'b0;
  logic          clr_err = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic [DW-1:0] csum;
  logic          rvalid;
  logic          ready;
  logic          werr;
`ifdef BOOTROM_LOCK_EN
  logic          lock = 1'b0;
`endif

  bootrom_patch dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .rvalid (rvalid),
    .ready  (ready),
    .csum   (csum),
    .rescan (rescan),
    .werr   (werr),
    .clr_err(clr_err)
`ifdef BOOTROM_LOCK_EN
    ,
    .lock   (lock)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW*DEPTH-1:0] init_img = {16'h0008, 16'h4000, 16'h6007, 16'hB007,
                                   16'hF400, 16'hF800, 16'h4000, 16'hF200};
  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < DEPTH; i++) model[i] = init_img[i*DW +: DW];
  endtask

  task automatic idle(input int n);
    cs = 1'b0;
    we = 1'b0;
    rescan = 1'b0;
    clr_err = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit expect_data);
    cs = 1'b1;
    we = 1'b0;
    addr = a;
    if (expect_data) sb.push_back('{d: model[a], due: cyc + 1});
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accepted);
    cs = 1'b1;
    we = 1'b1;
    addr = a;
    din = d;
    if (accepted) model[a] = d;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) break;
    end
    chk(tag, 32'(ready), 32'd1);
  endtask

  // Pops expectations when due; rvalid must be high exactly then and nowhere else.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("rvalid_due", 32'(rvalid), 32'd1);
      if (rvalid) chk("dout", 32'(dout), 32'(sb[0].d));
      void'(sb.pop_front());
    end else if (rvalid) begin
      chk("spurious_rvalid", 32'(rvalid), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    init_model();
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_csum", 32'(csum), 32'd0);
    chk("rst_werr", 32'(werr), 32'd0);

    // ready must stay low through edge 8 and rise on edge 9
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      chk("ready_scan", 32'(ready), (e == 9) ? 32'd1 : 32'd0);
    end
    chk("csum_boot", 32'(csum), 32'h6E16);
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) rd(AW'(i), 1'b1);
    idle(2);
    chk("dout_hold", 32'(dout), 32'h0008);

    wr(3'd7, 16'h1234, 1'b1);
    rd(3'd7, 1'b1);
    idle(2);
    chk("werr_patch_wr", 32'(werr), 32'd0);

    // rescan with a same-cycle read: the read is dropped
    rescan = 1'b1;
    cs = 1'b1;
    we = 1'b0;
    addr = 3'd0;
    @(posedge clk);
    #1;
    rescan = 1'b0;
    cs = 1'b0;
    chk("rescan_ready", 32'(ready), 32'd0);
    chk("rescan_csum_hold", 32'(csum), 32'h6E16);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (ready) break;
      n++;
    end
    chk("rescan_low_cycles", 32'(n), 32'd8);
    chk("rescan_csum", 32'(csum), 32'h8042);
    @(negedge clk);

    wr(3'd3, 16'hFFFF, 1'b0);
    rd(3'd3, 1'b1);
    idle(1);
    chk("werr_fixed_wr", 32'(werr), 32'd1);
    clr_err = 1'b1;
    wr(3'd3, 16'h0000, 1'b0);
    clr_err = 1'b0;
    chk("werr_err_wins", 32'(werr), 32'd1);
    cs = 1'b0;
    we = 1'b0;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("werr_clear", 32'(werr), 32'd0);

    // accesses during a scan are ignored, then reset aborts the scan
    rescan = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
    rd(3'd0, 1'b0);
    wr(3'd7, 16'h9999, 1'b0);
    wr(3'd3, 16'h9999, 1'b0);
    cs = 1'b0;
    we = 1'b0;
    chk("werr_scan_wr", 32'(werr), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_csum", 32'(csum), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    init_model();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("abort_reready");
    chk("abort_csum_rescan", 32'(csum), 32'h6E16);
    @(negedge clk);
    rd(3'd7, 1'b1);
    rd(3'd0, 1'b1);
    idle(2);

`ifdef BOOTROM_LOCK_EN
    lock = 1'b1;
    @(negedge clk);
    lock = 1'b0;
    wr(3'd7, 16'hAAAA, 1'b0);
    rd(3'd7, 1'b1);
    idle(1);
    chk("lock_werr", 32'(werr), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("lock_reready");
    @(negedge clk);
    wr(3'd7, 16'h5555, 1'b1);
    rd(3'd7, 1'b1);
    idle(2);
    chk("unlock_werr", 32'(werr), 32'd0);
`endif

    idle(3);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
